// File: rtl/serial_word_queue_pkg.sv
// Shared types and width helpers for the serial word queue.
// Holds the deserializer state enum and the pointer/count width functions.
package serial_word_queue_pkg;

  typedef enum logic {
    RECEIVE = 1'b0,
    HOLD    = 1'b1
  } des_state_t;

  // Pointer width for a power-of-two depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold an occupancy of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a free-running divider counter.
  function automatic int div_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/serial_word_queue_tick.sv
// Single-cycle tick enable every DIV clocks.
// Ports: clock1M, reset (sync, active-high), tick.
module tick_gen
  import serial_word_queue_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clock1M,
  input  logic reset,
  output logic tick
);

  localparam int CW = div_w(DIV);

  logic [CW-1:0] count;

  // With DIV == 1 the counter sits at 0, so tick stays high.
  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clock1M) begin
    if (reset || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_queue.sv
// Serial-in deserializer feeding a DEPTH-entry word FIFO with backpressure.
// Ports: clock1M, reset, data_in/write_in in; dequeue_in pop; data_out,
// data_valid, status_out, len_out, full_out, empty_out, overflow_out out.
module serial_word_queue
  import serial_word_queue_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int DES_DIV  = 10,
  parameter int FIFO_DIV = 100
) (
  input  logic                       clock1M,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int BC_W  = $clog2(DATA_W);

  logic des_tick;
  logic fifo_tick;

  tick_gen #(.DIV(DES_DIV)) u_des_tick (
    .clock1M (clock1M),
    .reset   (reset),
    .tick    (des_tick)
  );

  tick_gen #(.DIV(FIFO_DIV)) u_fifo_tick (
    .clock1M (clock1M),
    .reset   (reset),
    .tick    (fifo_tick)
  );

  des_state_t        state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic push;
  logic pop;
  logic ovf_set;

  assign full_out   = (len_out == CNT_W'(DEPTH));
  assign empty_out  = (len_out == '0);
  assign status_out = (state == RECEIVE);

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    pop       = fifo_tick && dequeue_in && !empty_out;
    // A held word may enter a full FIFO when a pop frees the slot.
    push      = fifo_tick && (state == HOLD) && (!full_out || pop);
    ovf_set   = des_tick && write_in && (state == HOLD);
    unique case (state)
      RECEIVE: begin
        if (des_tick && write_in) begin
          shreg_d = {shreg[DATA_W-2:0], data_in};
          if (bit_cnt == BC_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = HOLD;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (push) begin
          state_d = RECEIVE;
        end
      end
    endcase
  end

  always_ff @(posedge clock1M) begin
    if (reset) begin
      state        <= RECEIVE;
      shreg        <= '0;
      bit_cnt      <= '0;
      overflow_out <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      if (ovf_set) begin
        overflow_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock1M) begin
    if (push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clock1M) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len_out    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop;
      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      unique case (1'b1)
        (push && !pop): len_out <= len_out + 1'b1;
        (pop && !push): len_out <= len_out - 1'b1;
        default:        len_out <= len_out;
      endcase
    end
  end

endmodule
